// File: rtl/axi_slv_mem_pkg.sv
// Shared types and default geometry for the AXI4 memory responder.
// Holds the write/read FSM state encodings and the default-config localparams.
package axi_slv_mem_pkg;

   typedef enum logic [1:0] {
      W_IDLE,
      W_DATA,
      W_RESP
   } wr_state_t;

   typedef enum logic [1:0] {
      R_IDLE,
      R_FETCH,
      R_DATA
   } rd_state_t;

   localparam int LP_DATA_W    = 32;
   localparam int LP_MEM_DEPTH = 1024;
   localparam int LP_DW_BYTES  = LP_DATA_W / 8;
   localparam int LP_ADDR_LSB  = $clog2(LP_DW_BYTES);
   localparam int LP_IDX_W     = $clog2(LP_MEM_DEPTH);

endpackage

// File: rtl/axi_slv_mem_ram.sv
// Simple dual-port RAM: byte-enabled write port, registered read port.
// Ports: clk, rst (clears read register only), we/waddr/wdata/wstrb, re/raddr/rdata.
module axi_slv_mem_ram
   import axi_slv_mem_pkg::*;
#(
   parameter int DW    = LP_DATA_W,
   parameter int DEPTH = LP_MEM_DEPTH,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [DW-1:0] wdata,
   input  logic [DW/8-1:0] wstrb,
   input  logic          re,
   input  logic [AW-1:0] raddr,
   output logic [DW-1:0] rdata
);

   logic [DW-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) begin
         for (int b = 0; b < DW/8; b++) begin
            if (wstrb[b]) mem[waddr][8*b +: 8] <= wdata[8*b +: 8];
         end
      end
   end

   // Non-blocking semantics make a same-cycle read return the old word.
   always_ff @(posedge clk) begin
      if (rst) rdata <= '0;
      else if (re) rdata <= mem[raddr];
   end

endmodule

// File: rtl/axim_ctrl_axi_slave_mem.sv
// AXI4 INCR-only responder backed by on-chip RAM; independent write and read FSMs.
// Ports: clk, rst, AW/W/B and AR/R channels. Optional macro AXI_SLV_MEM_STALL_EN adds LFSR back-pressure.
module axim_ctrl_axi_slave_mem
   import axi_slv_mem_pkg::*;
#(
   parameter int C_S_AXI_ADDR_WIDTH = 32,
   parameter int C_S_AXI_DATA_WIDTH = LP_DATA_W,
   parameter int C_MEM_DEPTH        = LP_MEM_DEPTH
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic                            s_axi_awvalid,
   output logic                            s_axi_awready,
   input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s_axi_awaddr,
   input  logic [7:0]                      s_axi_awlen,
   input  logic                            s_axi_wvalid,
   output logic                            s_axi_wready,
   input  logic [C_S_AXI_DATA_WIDTH-1:0]   s_axi_wdata,
   input  logic [C_S_AXI_DATA_WIDTH/8-1:0] s_axi_wstrb,
   input  logic                            s_axi_wlast,
   output logic                            s_axi_bvalid,
   input  logic                            s_axi_bready,
   input  logic                            s_axi_arvalid,
   output logic                            s_axi_arready,
   input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s_axi_araddr,
   input  logic [7:0]                      s_axi_arlen,
   output logic                            s_axi_rvalid,
   input  logic                            s_axi_rready,
   output logic [C_S_AXI_DATA_WIDTH-1:0]   s_axi_rdata,
   output logic                            s_axi_rlast
);

   localparam int LSB   = $clog2(C_S_AXI_DATA_WIDTH / 8);
   localparam int IDX_W = $clog2(C_MEM_DEPTH);

   wr_state_t        wstate;
   rd_state_t        rstate;
   logic [IDX_W-1:0] widx, ridx, raddr;
   logic [7:0]       rlen, rcnt;
   logic             awready_q, wready_q, arready_q, rvalid_q;
   logic             aw_hs, w_hs, ar_hs, r_hs, re;
   logic             stall_w, stall_r, stall_a;

   // Address length and awlen are intentionally not used beyond the index bits.
   logic unused_bits;
   assign unused_bits = ^{s_axi_awaddr, s_axi_araddr, s_axi_awlen};

`ifdef AXI_SLV_MEM_STALL_EN
   logic [15:0] lfsr;
   always_ff @(posedge clk) begin
      if (rst) lfsr <= 16'hACE1;
      else     lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
   end
   assign stall_w = lfsr[0];
   assign stall_r = lfsr[1];
   assign stall_a = lfsr[2];
`else
   assign stall_w = 1'b0;
   assign stall_r = 1'b0;
   assign stall_a = 1'b0;
`endif

   assign s_axi_awready = awready_q & ~stall_a;
   assign s_axi_arready = arready_q & ~stall_a;
   assign s_axi_wready  = wready_q & ~stall_w;
   assign s_axi_rvalid  = rvalid_q & ~stall_r;

   assign aw_hs = s_axi_awvalid & s_axi_awready;
   assign w_hs  = s_axi_wvalid & s_axi_wready;
   assign ar_hs = s_axi_arvalid & s_axi_arready;
   assign r_hs  = s_axi_rvalid & s_axi_rready;

   always_ff @(posedge clk) begin
      if (rst) begin
         wstate       <= W_IDLE;
         awready_q    <= 1'b0;
         wready_q     <= 1'b0;
         s_axi_bvalid <= 1'b0;
         widx         <= '0;
      end else begin
         unique case (wstate)
            W_IDLE: begin
               if (aw_hs) begin
                  widx      <= s_axi_awaddr[LSB +: IDX_W];
                  awready_q <= 1'b0;
                  wready_q  <= 1'b1;
                  wstate    <= W_DATA;
               end else begin
                  awready_q <= 1'b1;
               end
            end
            W_DATA: begin
               if (w_hs) begin
                  widx <= widx + IDX_W'(1);
                  if (s_axi_wlast) begin
                     wready_q     <= 1'b0;
                     s_axi_bvalid <= 1'b1;
                     wstate       <= W_RESP;
                  end
               end
            end
            W_RESP: begin
               if (s_axi_bready) begin
                  s_axi_bvalid <= 1'b0;
                  awready_q    <= 1'b1;
                  wstate       <= W_IDLE;
               end
            end
            default: wstate <= W_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rstate      <= R_IDLE;
         arready_q   <= 1'b0;
         rvalid_q    <= 1'b0;
         s_axi_rlast <= 1'b0;
         ridx        <= '0;
         rlen        <= '0;
         rcnt        <= '0;
      end else begin
         unique case (rstate)
            R_IDLE: begin
               if (ar_hs) begin
                  ridx      <= s_axi_araddr[LSB +: IDX_W];
                  rlen      <= s_axi_arlen;
                  rcnt      <= '0;
                  arready_q <= 1'b0;
                  rstate    <= R_FETCH;
               end else begin
                  arready_q <= 1'b1;
               end
            end
            R_FETCH: begin
               rvalid_q    <= 1'b1;
               s_axi_rlast <= (rlen == 8'd0);
               rstate      <= R_DATA;
            end
            R_DATA: begin
               if (r_hs) begin
                  if (s_axi_rlast) begin
                     rvalid_q    <= 1'b0;
                     s_axi_rlast <= 1'b0;
                     arready_q   <= 1'b1;
                     rstate      <= R_IDLE;
                  end else begin
                     rcnt        <= rcnt + 8'd1;
                     ridx        <= ridx + IDX_W'(1);
                     s_axi_rlast <= ((rcnt + 8'd1) == rlen);
                  end
               end
            end
            default: rstate <= R_IDLE;
         endcase
      end
   end

   // Prefetch: while a non-last beat is accepted, fetch the following word.
   assign re    = (rstate == R_FETCH) || (r_hs && !s_axi_rlast);
   assign raddr = (rstate == R_DATA) ? ridx + IDX_W'(1) : ridx;

   axi_slv_mem_ram #(
      .DW    (C_S_AXI_DATA_WIDTH),
      .DEPTH (C_MEM_DEPTH)
   ) u_ram (
      .clk   (clk),
      .rst   (rst),
      .we    (w_hs),
      .waddr (widx),
      .wdata (s_axi_wdata),
      .wstrb (s_axi_wstrb),
      .re    (re),
      .raddr (raddr),
      .rdata (s_axi_rdata)
   );

endmodule

// File: tb/tb_axim_ctrl_axi_slave_mem.sv
// Self-checking bench for axim_ctrl_axi_slave_mem (default build, no stall LFSR).
// Directed bursts plus a strobe/address table with hand-computed expectations.
module tb_axim_ctrl_axi_slave_mem;

   logic        clk = 1'b0;
   logic        rst;
   logic        awvalid, awready, wvalid, wready, wlast, bvalid, bready;
   logic        arvalid, arready, rvalid, rready, rlast;
   logic [31:0] awaddr, araddr, wdata, rdata;
   logic [7:0]  awlen, arlen;
   logic [3:0]  wstrb;

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int vecs = 0;
   int miss = 0;
   logic [31:0] wbuf [8];
   logic [31:0] rexp [8];

   typedef struct {
      logic [31:0] waddr;
      logic [31:0] raddr;
      logic [31:0] pre;
      logic [31:0] wd;
      logic [3:0]  strb;
      logic [31:0] exp;
   } vec_t;

   vec_t tbl [6];

   axim_ctrl_axi_slave_mem dut (
      .clk           (clk),
      .rst           (rst),
      .s_axi_awvalid (awvalid),
      .s_axi_awready (awready),
      .s_axi_awaddr  (awaddr),
      .s_axi_awlen   (awlen),
      .s_axi_wvalid  (wvalid),
      .s_axi_wready  (wready),
      .s_axi_wdata   (wdata),
      .s_axi_wstrb   (wstrb),
      .s_axi_wlast   (wlast),
      .s_axi_bvalid  (bvalid),
      .s_axi_bready  (bready),
      .s_axi_arvalid (arvalid),
      .s_axi_arready (arready),
      .s_axi_araddr  (araddr),
      .s_axi_arlen   (arlen),
      .s_axi_rvalid  (rvalid),
      .s_axi_rready  (rready),
      .s_axi_rdata   (rdata),
      .s_axi_rlast   (rlast)
   );

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      vecs++;
      if (act !== exp) begin
         miss++;
         $display("FAIL %s: got %08h want %08h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic axi_wr(input logic [31:0] addr, input int n,
                         input logic [3:0] strb, input int bdelay);
      int t;
      awvalid = 1'b1;
      awaddr  = addr;
      awlen   = 8'(n - 1);
      t = 0;
      while (!awready && t < 50) begin step(); t++; end
      chk("aw_ready", 32'(awready), 32'd1);
      step();
      awvalid = 1'b0;
      for (int i = 0; i < n; i++) begin
         wvalid = 1'b1;
         wdata  = wbuf[i];
         wstrb  = strb;
         wlast  = (i == n - 1);
         t = 0;
         while (!wready && t < 50) begin step(); t++; end
         chk("w_ready", 32'(wready), 32'd1);
         chk("b_early", 32'(bvalid), 32'd0);
         step();
      end
      wvalid = 1'b0;
      wlast  = 1'b0;
      t = 0;
      while (!bvalid && t < 50) begin step(); t++; end
      chk("b_valid", 32'(bvalid), 32'd1);
      for (int k = 0; k < bdelay; k++) begin
         chk("b_hold", 32'(bvalid), 32'd1);
         chk("aw_blocked", 32'(awready), 32'd0);
         step();
      end
      bready = 1'b1;
      step();
      bready = 1'b0;
      chk("b_drop", 32'(bvalid), 32'd0);
   endtask

   task automatic axi_rd(input logic [31:0] addr, input int n);
      int t;
      int ar_cyc;
      arvalid = 1'b1;
      araddr  = addr;
      arlen   = 8'(n - 1);
      t = 0;
      while (!arready && t < 50) begin step(); t++; end
      chk("ar_ready", 32'(arready), 32'd1);
      ar_cyc = cyc;
      step();
      arvalid = 1'b0;
      rready  = 1'b1;
      for (int i = 0; i < n; i++) begin
         t = 0;
         while (!rvalid && t < 50) begin step(); t++; end
         chk("r_valid", 32'(rvalid), 32'd1);
         if (i == 0) chk("r_latency", 32'(cyc - ar_cyc), 32'd2);
         else        chk("r_bubble", 32'(t), 32'd0);
         chk("r_data", rdata, rexp[i]);
         chk("r_last", 32'(rlast), 32'(i == n - 1));
         step();
      end
      rready = 1'b0;
      chk("r_drop", 32'(rvalid), 32'd0);
   endtask

   initial begin : main
      int beat;
      logic hold_v;
      logic [31:0] hold_d;
      int pat [4];

      tbl[0] = '{32'h200, 32'h200, 32'h0000_0000, 32'hAABB_CCDD, 4'h5, 32'h00BB_00DD};
      tbl[1] = '{32'h204, 32'h204, 32'h0000_0000, 32'hAABB_CCDD, 4'hA, 32'hAA00_CC00};
      tbl[2] = '{32'h208, 32'h208, 32'hFFFF_FFFF, 32'h1234_5678, 4'hF, 32'h1234_5678};
      tbl[3] = '{32'h20C, 32'h20C, 32'hCAFE_BABE, 32'h1234_5678, 4'h0, 32'hCAFE_BABE};
      tbl[4] = '{32'h213, 32'h210, 32'h1122_3344, 32'h0000_BEEF, 4'h3, 32'h1122_BEEF};
      tbl[5] = '{32'h1000_0300, 32'h300, 32'h0, 32'h7654_3210, 4'hF, 32'h7654_3210};
      pat = '{1, 0, 0, 1};

      rst = 1'b1;
      {awvalid, wvalid, wlast, bready, arvalid, rready} = '0;
      awaddr = '0; araddr = '0; awlen = '0; arlen = '0;
      wdata = '0; wstrb = '0;
      step(); step();
      chk("rst_ctl", {25'd0, awready, wready, bvalid, arready, rvalid, rlast, 1'b0}, 32'd0);
      chk("rst_rdata", rdata, 32'd0);
      rst = 1'b0;
      chk("rst_after_ctl", {25'd0, awready, wready, bvalid, arready, rvalid, rlast, 1'b0}, 32'd0);
      chk("rst_after_rdata", rdata, 32'd0);
      step();

      // Basic 4-beat write then read back.
      wbuf = '{32'h1111_1111, 32'h2222_2222, 32'h3333_3333, 32'h4444_4444,
               32'h0, 32'h0, 32'h0, 32'h0};
      axi_wr(32'h100, 4, 4'hF, 0);
      rexp = wbuf;
      axi_rd(32'h100, 4);

      // Strobe / address-index table.
      for (int v = 0; v < 6; v++) begin
         wbuf[0] = tbl[v].pre;
         axi_wr(tbl[v].waddr, 1, 4'hF, 0);
         wbuf[0] = tbl[v].wd;
         axi_wr(tbl[v].waddr, 1, tbl[v].strb, 0);
         rexp[0] = tbl[v].exp;
         axi_rd(tbl[v].raddr, 1);
      end

      // Read with rready pattern 1,0,0,1.
      wbuf = '{32'hA0A0_0000, 32'hA1A1_0001, 32'hA2A2_0002, 32'hA3A3_0003,
               32'h0, 32'h0, 32'h0, 32'h0};
      axi_wr(32'h400, 4, 4'hF, 0);
      arvalid = 1'b1; araddr = 32'h400; arlen = 8'd3;
      chk("stall_ar", 32'(arready), 32'd1);
      step();
      arvalid = 1'b0;
      beat = 0; hold_v = 1'b0; hold_d = '0;
      for (int k = 0; k < 40 && beat < 4; k++) begin
         rready = (pat[k % 4] != 0);
         if (hold_v) begin
            chk("stall_hold", rdata, hold_d);
            hold_v = 1'b0;
         end
         if (rvalid) begin
            if (rready) begin
               chk("stall_data", rdata, wbuf[beat]);
               chk("stall_last", 32'(rlast), 32'(beat == 3));
               beat++;
            end else begin
               hold_v = 1'b1;
               hold_d = rdata;
            end
         end
         step();
      end
      rready = 1'b0;
      chk("stall_beats", 32'(beat), 32'd4);
      chk("stall_end", 32'(rvalid), 32'd0);

      // Index wrap at the top of the RAM.
      wbuf[0] = 32'h5A5A_0001;
      wbuf[1] = 32'h5A5A_0002;
      axi_wr(32'hFFC, 2, 4'hF, 0);
      rexp[0] = 32'h5A5A_0001;
      axi_rd(32'hFFC, 1);
      rexp[0] = 32'h5A5A_0002;
      axi_rd(32'h0, 1);

      // Concurrent write and read of the same burst: read sees old data.
      wbuf = '{32'h9999_0000, 32'h9999_0001, 32'h9999_0002, 32'h9999_0003,
               32'h0, 32'h0, 32'h0, 32'h0};
      rexp = '{32'h1111_1111, 32'h2222_2222, 32'h3333_3333, 32'h4444_4444,
               32'h0, 32'h0, 32'h0, 32'h0};
      fork
         axi_wr(32'h100, 4, 4'hF, 5);
         axi_rd(32'h100, 4);
      join
      rexp = wbuf;
      axi_rd(32'h100, 4);

      // Reset during beat 2 of an 8-beat read.
      arvalid = 1'b1; araddr = 32'h100; arlen = 8'd7;
      chk("rr_ar", 32'(arready), 32'd1);
      step();
      arvalid = 1'b0;
      rready = 1'b1;
      step();
      chk("rr_beat1", rdata, 32'h9999_0000);
      step();
      chk("rr_beat2", rdata, 32'h9999_0001);
      rst = 1'b1;
      step();
      rst = 1'b0;
      rready = 1'b0;
      chk("rr_rvalid", 32'(rvalid), 32'd0);
      chk("rr_ctl", {25'd0, awready, wready, bvalid, arready, rvalid, rlast, 1'b0}, 32'd0);
      chk("rr_rdata", rdata, 32'd0);
      step();
      chk("rr_arready", 32'(arready), 32'd1);
      rexp[0] = 32'h9999_0002;
      axi_rd(32'h108, 1);

      $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
      $finish;
   end

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/axim_ctrl_axi_slave_mem.md
Name: axim_ctrl_axi_slave_mem

Overview:
- AXI4 memory-mapped responder (slave) backed by on-chip RAM.
- Implements the same signal subset the vector AXI master drives: AW/W/B/AR/R, INCR bursts only, no IDs/size/burst/resp fields.
- Serves as the far end of the vector load/store master; used in simulation and as a scratchpad in FPGA builds.
- Read and write channels are independent and may be active concurrently.

Parameters:
- C_S_AXI_ADDR_WIDTH, 32, byte address width.
- C_S_AXI_DATA_WIDTH, 32, data width; power of two, 32..512.
- C_MEM_DEPTH, 1024, RAM depth in data words; power of two.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- s_axi_awvalid  in  1  write address valid.
- s_axi_awready  out  1  write address ready.
- s_axi_awaddr  in  C_S_AXI_ADDR_WIDTH  burst start byte address.
- s_axi_awlen  in  8  beats-1.
- s_axi_wvalid  in  1  write data valid.
- s_axi_wready  out  1  write data ready.
- s_axi_wdata  in  C_S_AXI_DATA_WIDTH  write data.
- s_axi_wstrb  in  C_S_AXI_DATA_WIDTH/8  byte enables.
- s_axi_wlast  in  1  last write beat.
- s_axi_bvalid  out  1  write response valid.
- s_axi_bready  in  1  write response ready.
- s_axi_arvalid  in  1  read address valid.
- s_axi_arready  out  1  read address ready.
- s_axi_araddr  in  C_S_AXI_ADDR_WIDTH  burst start byte address.
- s_axi_arlen  in  8  beats-1.
- s_axi_rvalid  out  1  read data valid.
- s_axi_rready  in  1  read data ready.
- s_axi_rdata  out  C_S_AXI_DATA_WIDTH  read data.
- s_axi_rlast  out  1  last read beat.

Behaviour:
- Reset: the one clock is clk. rst is synchronous and active-high; these are fixed. While rst=1 and on the first cycle after it, all outputs are 0: awready, wready, bvalid, arready, rvalid, rlast and rdata. RAM contents are not reset.
- Word index: addr[LSB +: log2(C_MEM_DEPTH)], where LSB = log2(bytes per beat). Unaligned low address bits are ignored. Index wraps modulo C_MEM_DEPTH; out-of-range upper address bits are ignored, never an error.
- Write FSM:
  - W_IDLE: awready=1. On AW handshake, latch index, go to W_DATA.
  - W_DATA: wready=1. Each W handshake writes the bytes with wstrb=1 at the current index, then index+1 with wrap.
  - The burst ends only on a wlast handshake, then W_RESP. awlen is not checked; beats beyond awlen+1 keep incrementing.
  - W_RESP: bvalid=1, held until bready, then W_IDLE.
  - bvalid is never asserted before the wlast beat has been written.
- Read FSM:
  - R_IDLE: arready=1. On AR handshake, latch index and arlen, clear beat counter, go to R_FETCH.
  - R_FETCH: one-cycle RAM read, go to R_DATA.
  - R_DATA: rvalid=1; rlast=1 when beat counter == latched arlen.
  - Handshake with rlast=0: counter+1, index+1, next word presented the next cycle (pipelined prefetch, no bubble). Throughput is one beat per cycle under continuous rready.
  - Handshake with rlast=1: go to R_IDLE; rvalid drops next cycle.
  - Latency: AR handshake at cycle N gives first rvalid at N+2.
  - rvalid=1 with rready=0: rdata and rlast are held stable.
- arlen=0 or awlen=0: single-beat burst, handled normally.
- Same-cycle write and read of the same word: read-first, returning old data. A read issued after the B handshake sees the new data.
- rst asserted mid-burst: both FSMs go to IDLE next cycle and the burst is abandoned. Partial writes already done remain in RAM.

Optional Feature:
- Macro AXI_SLV_MEM_STALL_EN.
- Defined: a 16-bit LFSR (seed 16'hACE1, reset by rst) gates the ready/valid outputs:
  - wready in W_DATA is masked when lfsr[0]=1.
  - rvalid in R_DATA advance is masked when lfsr[1]=1; no beat is presented or dropped in that cycle, and data is held.
  - awready and arready are masked when lfsr[2]=1.
- Not defined: no LFSR; the timing above is exact.

Decomposition:
- Package axi_slv_mem_pkg: wr_state_t {W_IDLE, W_DATA, W_RESP}, rd_state_t {R_IDLE, R_FETCH, R_DATA}, localparams LP_DW_BYTES, LP_ADDR_LSB, LP_IDX_W.
- Sub-module axi_slv_mem_ram: simple dual-port RAM, one write port with per-byte enables, one registered read port (read-first), single clock.

Test Plan:
- After reset, AW addr 0x100, awlen=3, W data 0x11111111..0x44444444 with wstrb=0xF and wlast on beat 4 → one bvalid. Then AR 0x100, arlen=3 → rdata 0x11111111..0x44444444, rlast only on beat 4, first rvalid 2 cycles after AR.
- Write 0xAABBCCDD to 0x200 with wstrb=0x5 over 0x00000000 → read of 0x200 returns 0x00BB00DD.
- rready toggled 1,0,0,1 during a 4-beat read → no beat lost or duplicated; rdata stable while stalled.
- C_MEM_DEPTH=1024: write a 2-beat burst at 0xFFC → second beat lands at index 0; read 0x0 returns it.
- Concurrent write and read bursts to the same address → read returns pre-write values. bready held low 5 cycles → bvalid held, AW not accepted.
- rst pulsed during beat 2 of an 8-beat read → rvalid=0 next cycle; a new AR is accepted 2 cycles later.
